// File: rtl/dense_bias_argmax.sv
// Final CIFAR-10 classifier stage: adds per-class bias to dense dot products and streams out the argmax.
// Optional macro BIAS_SAT_EN saturates the biased sum; undefined, the sum wraps to ACC_W bits.
module dense_bias_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int ACC_W       = 24,
    parameter int ACC_FRAC    = 14,
    parameter int BIAS_W      = 8,
    parameter int BIAS_FRAC   = 7,
    parameter int IDX_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [ACC_W-1:0]  in_acc,
    input  logic                     in_last,
    output logic [15:0]              bias_row,
    output logic [15:0]              bias_col,
    input  logic signed [BIAS_W-1:0] bias_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_class,
    output logic [ACC_W-1:0]         out_score,
    output logic                     frame_err
);

    localparam int SHIFT = ACC_FRAC - BIAS_FRAC;
`ifdef BIAS_SAT_EN
    localparam int SUM_W = ACC_W + 1;
`else
    // An ACC_W-wide add yields exactly the wrapped result of the wider sum
    localparam int SUM_W = ACC_W;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic {
        ST_COLLECT,
        ST_RESULT
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_best_idx;
    logic signed [ACC_W-1:0] r_best_score;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [IDX_W-1:0]        r_out_class;
    logic [ACC_W-1:0]        r_out_score;
    logic                    r_frame_err;

    logic signed [SUM_W-1:0] w_bias_sh;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_biased;
    logic                    w_accept;
    logic                    w_at_last;
    logic                    w_take;
    logic signed [ACC_W-1:0] w_new_score;
    logic [IDX_W-1:0]        w_new_idx;

    always_comb begin
        w_bias_sh = SUM_W'(bias_data) <<< SHIFT;
        w_sum     = SUM_W'(in_acc) + w_bias_sh;
    end

`ifdef BIAS_SAT_EN
    always_comb begin
        if (w_sum[SUM_W-1] != w_sum[ACC_W-1]) begin
            w_biased = w_sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            w_biased = w_sum[ACC_W-1:0];
        end
    end
`else
    assign w_biased = w_sum;
`endif

    // First class of a frame always seeds the running max; later ones need a strict win
    always_comb begin
        w_accept    = in_valid & r_in_ready;
        w_at_last   = (r_cnt == LAST_IDX);
        w_take      = (r_cnt == '0) || (w_biased > r_best_score);
        w_new_score = w_take ? w_biased : r_best_score;
        w_new_idx   = w_take ? r_cnt : r_best_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_COLLECT;
            r_cnt        <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_class  <= '0;
            r_out_score  <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_best_score <= w_new_score;
                        r_best_idx   <= w_new_idx;
                        r_frame_err  <= (in_last != w_at_last);
                        if (w_at_last) begin
                            r_cnt       <= '0;
                            r_out_class <= w_new_idx;
                            r_out_score <= w_new_score;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= ST_RESULT;
                        end else begin
                            r_cnt <= r_cnt + IDX_W'(1);
                        end
                    end
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_COLLECT;
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign bias_row  = 16'(r_cnt);
    assign bias_col  = '0;
    assign out_valid = r_out_valid;
    assign out_class = r_out_class;
    assign out_score = r_out_score;
    assign frame_err = r_frame_err;

endmodule
